md_stall_unit: RTL and testbench

Hazard and stall controller for the multiply/divide unit in the five-stage pipeline. It sits between the decode-stage control and the E-stage MDU. It mirrors the MDU's multi-cycle occupancy with its own state machine and freezes F/D while an MD-class instruction in D would collide with an in-flight multiply/divide. It also raises a sticky error when its mirror disagrees with the MDU's `busy`, and counts stall cycles for performance debug.

---
 rtl/md_stall_unit_if.sv | 24 ++
 rtl/md_stall_unit.sv | 83 ++++++++
 tb/tb_md_stall_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/md_stall_unit_if.sv
// Handshake bundle between decode control, the E-stage MDU and the MD stall unit.
// The slave side is the stall unit; the master side is the surrounding pipeline.
interface md_stall_unit_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       MDUtype_D;
  logic [3:0]       MDUtype_E;
  logic             busy_E;
  logic             stall;
  logic             flush_E;
  logic [3:0]       remain;
  logic [CNT_W-1:0] stall_cnt;
  logic             mismatch;

  modport slave (
    input  MDUtype_D, MDUtype_E, busy_E,
    output stall, flush_E, remain, stall_cnt, mismatch
  );

  modport master (
    output MDUtype_D, MDUtype_E, busy_E,
    input  stall, flush_E, remain, stall_cnt, mismatch
  );
endinterface

// File: rtl/md_stall_unit.sv
// MDU occupancy mirror: stalls F/D while an MD-class op in D would collide with an
// in-flight multiply/divide, flags mirror/MDU disagreement, counts stall cycles.
module md_stall_unit #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 32
) (
  input logic             clk,
  input logic             reset,
  md_stall_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MULT_WAIT, DIV_WAIT} state_t;

  localparam logic [3:0] MULT_INIT = 4'(MULT_CYC);
  localparam logic [3:0] DIV_INIT  = 4'(DIV_CYC);

  state_t           state, state_nxt;
  logic [3:0]       remain_q, remain_nxt;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             mismatch_q, mismatch_nxt;
  logic             md_d, start_e, is_mult_e, busy_mirror, stall_int;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign md_d        = (bus.MDUtype_D >= 4'd1) && (bus.MDUtype_D <= 4'd8);
  assign start_e     = (bus.MDUtype_E >= 4'd1) && (bus.MDUtype_E <= 4'd4);
  assign is_mult_e   = (bus.MDUtype_E == 4'd1) || (bus.MDUtype_E == 4'd2);
  assign busy_mirror = (state != IDLE);

  // Gated by reset so the pipeline is never frozen while the MDU is held in reset.
  assign stall_int = reset && md_d && (start_e || busy_mirror);

  always_comb begin
    state_nxt    = state;
    remain_nxt   = remain_q;
    mismatch_nxt = mismatch_q | (busy_mirror != bus.busy_E) | (start_e && busy_mirror);
    case (state)
      IDLE: begin
        if (start_e) begin
          state_nxt  = is_mult_e ? MULT_WAIT : DIV_WAIT;
          remain_nxt = is_mult_e ? MULT_INIT : DIV_INIT;
        end
      end
      MULT_WAIT, DIV_WAIT: begin
        // A start seen here is ignored (the MDU ignores it too) and only flagged.
        if (remain_q > 4'd1) begin
          remain_nxt = remain_q - 4'd1;
        end else begin
          state_nxt  = IDLE;
          remain_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        remain_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      remain_q    <= 4'd0;
      stall_cnt_q <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      remain_q   <= remain_nxt;
      mismatch_q <= mismatch_nxt;
      if (stall_int) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign bus.stall     = stall_int;
  assign bus.flush_E   = stall_int;
  assign bus.remain    = remain_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.mismatch  = mismatch_q;

endmodule

// File: tb/tb_md_stall_unit.sv
// Directed bench for md_stall_unit: a 32-bit counter instance plus a 4-bit one
// sharing the same stimulus to exercise counter saturation.
module tb_md_stall_unit;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  md_stall_unit_if #(.CNT_W(32)) bus ();
  md_stall_unit_if #(.CNT_W(4))  bus4 ();

  md_stall_unit #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  md_stall_unit #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  assign bus4.MDUtype_D = bus.MDUtype_D;
  assign bus4.MDUtype_E = bus.MDUtype_E;
  assign bus4.busy_E    = bus.busy_E;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and move to the sampling point (falling edge).
  task automatic set(input logic [3:0] d, input logic [3:0] e, input logic b);
    bus.MDUtype_D = d;
    bus.MDUtype_E = e;
    bus.busy_E    = b;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.MDUtype_D = 4'd0;
    bus.MDUtype_E = 4'd0;
    bus.busy_E    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Post-reset state
    set(4'd0, 4'd0, 1'b0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_remain", bus.remain, 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    chk("rst_mismatch", bus.mismatch, 0);
    adv();

    // mult in E, mfhi in D: stall cycles 0..5
    set(4'd5, 4'd1, 1'b0);
    chk("mult_issue_stall", bus.stall, 1);
    chk("mult_issue_flush", bus.flush_E, 1);
    chk("mult_issue_remain", bus.remain, 0);
    adv();
    for (int k = 1; k <= 5; k++) begin
      set(4'd5, 4'd0, 1'b1);
      chk("mult_wait_stall", bus.stall, 1);
      chk("mult_wait_remain", bus.remain, 64'(6 - k));
      adv();
    end
    set(4'd0, 4'd0, 1'b0);
    chk("mult_done_stall", bus.stall, 0);
    chk("mult_done_remain", bus.remain, 0);
    chk("mult_cnt", bus.stall_cnt, 6);
    chk("mult_cnt4", bus4.stall_cnt, 6);
    chk("mult_mismatch", bus.mismatch, 0);
    adv();

    // divu in E, mflo in D: 11 stall cycles
    set(4'd6, 4'd4, 1'b0);
    chk("div_issue_stall", bus.stall, 1);
    adv();
    for (int k = 1; k <= 10; k++) begin
      set(4'd6, 4'd0, 1'b1);
      chk("div_wait_stall", bus.stall, 1);
      chk("div_wait_remain", bus.remain, 64'(11 - k));
      adv();
    end
    set(4'd6, 4'd0, 1'b0);
    chk("div_release_stall", bus.stall, 0);
    chk("div_release_remain", bus.remain, 0);
    chk("div_cnt", bus.stall_cnt, 17);
    chk("div_cnt4_sat", bus4.stall_cnt, 15);
    chk("div_mismatch", bus.mismatch, 0);
    adv();

    // mult in E, addu in D twice, then mfhi arrives at cycle 3
    set(4'd0, 4'd1, 1'b0);
    chk("late_c0_stall", bus.stall, 0);
    adv();
    set(4'd0, 4'd0, 1'b1);
    chk("late_c1_stall", bus.stall, 0);
    adv();
    set(4'd0, 4'd0, 1'b1);
    chk("late_c2_stall", bus.stall, 0);
    adv();
    for (int k = 3; k <= 5; k++) begin
      set(4'd5, 4'd0, 1'b1);
      chk("late_wait_stall", bus.stall, 1);
      chk("late_wait_remain", bus.remain, 64'(6 - k));
      adv();
    end
    set(4'd5, 4'd0, 1'b0);
    chk("late_free_stall", bus.stall, 0);
    chk("late_cnt", bus.stall_cnt, 20);
    chk("late_cnt4_sat", bus4.stall_cnt, 15);
    adv();

    // mthi in E, mflo in D: no start, no stall
    set(4'd6, 4'd7, 1'b0);
    chk("mthi_stall", bus.stall, 0);
    adv();
    set(4'd6, 4'd0, 1'b0);
    chk("mthi_next_stall", bus.stall, 0);
    chk("mthi_remain", bus.remain, 0);
    chk("mthi_cnt", bus.stall_cnt, 20);
    chk("mthi_mismatch", bus.mismatch, 0);
    adv();

    // div started, async reset in the middle of cycle 4
    set(4'd0, 4'd3, 1'b0);
    adv();
    for (int k = 1; k <= 3; k++) begin
      set(4'd0, 4'd0, 1'b1);
      adv();
    end
    bus.MDUtype_D = 4'd5;
    bus.MDUtype_E = 4'd0;
    bus.busy_E    = 1'b1;
    #1;
    chk("rstmid_pre_stall", bus.stall, 1);
    chk("rstmid_pre_remain", bus.remain, 7);
    reset = 1'b0;
    #1;
    chk("rstmid_remain", bus.remain, 0);
    chk("rstmid_stall", bus.stall, 0);
    chk("rstmid_flush", bus.flush_E, 0);
    chk("rstmid_cnt", bus.stall_cnt, 0);
    chk("rstmid_cnt4", bus4.stall_cnt, 0);
    adv();
    chk("rstheld_stall", bus.stall, 0);
    bus.busy_E = 1'b0;
    reset = 1'b1;
    set(4'd5, 4'd0, 1'b0);
    chk("rstrel_stall", bus.stall, 0);
    chk("rstrel_remain", bus.remain, 0);
    chk("rstrel_mismatch", bus.mismatch, 0);
    adv();

    // busy_E high while idle for one edge: sticky mismatch
    set(4'd0, 4'd0, 1'b1);
    chk("busyidle_pre", bus.mismatch, 0);
    adv();
    set(4'd0, 4'd0, 1'b0);
    chk("busyidle_set", bus.mismatch, 1);
    adv();
    set(4'd0, 4'd0, 1'b0);
    chk("busyidle_hold", bus.mismatch, 1);
    reset = 1'b0;
    #1;
    chk("mismatch_clear", bus.mismatch, 0);
    reset = 1'b1;
    adv();

    // Second start while busy: ignored by the mirror, flagged
    set(4'd0, 4'd1, 1'b0);
    adv();
    set(4'd0, 4'd2, 1'b1);
    chk("dblstart_pre", bus.mismatch, 0);
    chk("dblstart_remain", bus.remain, 5);
    adv();
    set(4'd0, 4'd0, 1'b1);
    chk("dblstart_set", bus.mismatch, 1);
    chk("dblstart_ignored", bus.remain, 4);
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
